axi4_lite_write_arbiter: RTL and testbench
==========================================

// Module: axi4_lite_write_arbiter
// PURPOSE
//  Shares one AXI4-Lite write master between NUM_REQ local requesters.
//  Picks one pending request round-robin and holds its addr/data/strb in registers.
//  Pulses the master's wr_en, then monitors the B channel to see the write finish.
//  Returns done+resp to the granted requester. Sits between CSR/DMA clients and the write master.
// PARAMETERS
//  NUM_REQ     4   number of requesters; legal range 2..16
//  ADDR_WIDTH  32  address width, identical to the write master's
//  DATA_WIDTH  32  data width, identical to the write master's; strobe width = DATA_WIDTH/8
// PORTS
//  clk          in   1                    single clock for the whole block
//  reset        in   1                    asynchronous, active-high; top inverts it to drive the master's resetn
//  req          in   NUM_REQ              per-requester request level
//  req_addr     in   NUM_REQ*ADDR_WIDTH   requester i uses [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_data     in   NUM_REQ*DATA_WIDTH   requester i uses [i*DATA_WIDTH +: DATA_WIDTH]
//  req_strb     in   NUM_REQ*DATA_WIDTH/8 requester i byte strobes
//  gnt          out  NUM_REQ              one-hot; held from grant until done
//  done         out  NUM_REQ              one-cycle pulse to the granted requester on completion
//  resp         out  2                    BRESP of the completed write; valid while done!=0
//  busy         out  1                    high in every state except IDLE
//  m_wr_en      out  1                    write-start pulse to the master
//  m_wr_addr    out  ADDR_WIDTH           registered; stable from grant through DONE
//  m_wr_data    out  DATA_WIDTH           registered; stable from grant through DONE
//  m_wr_strb    out  DATA_WIDTH/8         registered; stable from grant through DONE
//  m_b_valid    in   1                    B_VALID, monitored only
//  m_b_ready    in   1                    master's B_READY, monitored only
//  m_b_resp     in   2                    B_RESP, monitored only
// BEHAVIOUR
//  Reset values: all outputs 0, state=IDLE, rr pointer=0. Reset is asynchronous.
//  FSM states: IDLE -> ISSUE -> WAIT_RESP -> DONE -> IDLE.
//  IDLE
//   - If req!=0, select the first set bit at or above ptr, wrapping from NUM_REQ-1 to 0.
//   - Register gnt, addr, data and strb; next state is ISSUE.
//  ISSUE
//   - m_wr_en=1 for exactly one cycle; next state is WAIT_RESP.
//  WAIT_RESP
//   - Completion is the cycle where m_b_valid && m_b_ready.
//   - On that cycle, register resp<=m_b_resp; next state is DONE.
//  DONE
//   - done=gnt for one cycle.
//   - gnt clears the following cycle.
//   - ptr <= granted index+1, modulo NUM_REQ; next state is IDLE.
//  Latency: req seen in IDLE at cycle 0, then gnt and m_* registered at cycle 1, and m_wr_en high in cycle 1.
//  Minimum total: B handshake at cycle k gives done at cycle k+1.
//  Back-to-back: the next arbitration happens in the IDLE cycle after DONE.
//   - A single steady requester is therefore serviced every (B latency + 3) cycles.
//  req is sampled only in IDLE. Dropping req after grant does not abort the write.
//   - done still pulses.
//  Simultaneous requests: round-robin gives no starvation.
//   - Each active requester waits at most NUM_REQ-1 writes.
//  Non-OKAY BRESP (2'b10/2'b11) is passed through unchanged. No retry.
//  A B handshake outside WAIT_RESP is ignored; it must not occur.
//  Reset mid-transaction: return to IDLE immediately, all outputs 0, no done pulse.
//  A pending req is re-arbitrated from ptr=0 after reset.
//  Requester data is copied at grant, so changes to req_* after grant have no effect.
// STRUCTURE
//  Package axi4_lite_pkg:
//   - state enum (2-bit): IDLE, ISSUE, WAIT_RESP, DONE
//   - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
//  Sub-module rr_arbiter: combinational masked priority pick.
//   - Inputs req and ptr; outputs a one-hot grant and a binary index.
//   - Parameterised by NUM_REQ; ptr width = $clog2(NUM_REQ).
//  Top level: FSM, payload capture mux and registers, resp register.
// TESTING
//  1. Single request: req=4'b0001, addr=0x10, data=0xDEADBEEF, B after 2 cycles.
//     -> m_wr_en for 1 cycle, m_wr_addr=0x10, done=4'b0001, resp=00.
//  2. All four requests held high for 8 transactions.
//     -> grant order 0,1,2,3,0,1,2,3; each gnt is one-hot.
//  3. ptr=3 after a grant to requester 2, then req=4'b0011.
//     -> requester 0 is granted (wrap), then requester 1.
//  4. Slave returns m_b_resp=2'b10.
//     -> resp=2'b10 alongside the done pulse; the next request proceeds normally.
//  5. Assert reset during WAIT_RESP.
//     -> gnt=0, busy=0 and m_wr_en=0 in the same cycle; no done pulse; ptr=0.
//  6. Drop req and change req_data after grant.
//     -> m_wr_data keeps the captured value; done still pulses once.

Source files
------------

// File: rtl/axi4_lite_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi4_lite_pkg
//
// Shared types and constants for the AXI4-Lite write arbiter slice.
//
// Contents:
//   state_t      - 2-bit arbiter FSM state (IDLE, ISSUE, WAIT_RESP, DONE)
//   RESP_*       - AXI4-Lite BRESP encodings
//   is_error_resp - helper that flags SLVERR/DECERR responses
// ---------------------------------------------------------------------------
package axi4_lite_pkg;

    // Arbiter FSM. The walk is strictly IDLE -> ISSUE -> WAIT_RESP -> DONE -> IDLE.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } state_t;

    // BRESP encodings as defined by AXI4-Lite.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Both error encodings have the upper bit set, so clients can test
    // a single bit instead of comparing against two constants.
    function automatic logic is_error_resp(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi4_lite_write_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Combinational round-robin pick. Starting at position ptr and walking
// upward (wrapping from NUM_REQ-1 back to 0), the first requester with its
// req bit set wins.
//
// Parameters:
//   NUM_REQ    number of requesters (2..16)
//   PTR_WIDTH  width of ptr / idx, $clog2(NUM_REQ)
//
// Ports:
//   req   in   NUM_REQ     request vector
//   ptr   in   PTR_WIDTH   highest-priority position for this pick
//   gnt   out  NUM_REQ     one-hot winner, all zero when req == 0
//   idx   out  PTR_WIDTH   binary index of the winner, 0 when req == 0
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PTR_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [PTR_WIDTH-1:0] idx
);

    // Rotate the search origin to ptr and take the first set bit. The
    // candidate position is computed one bit wider than ptr so that the
    // wrap works for non-power-of-two NUM_REQ as well: ptr + i never exceeds
    // 2*NUM_REQ-2, so a single conditional subtract is enough.
    always_comb begin
        logic [PTR_WIDTH:0]   sum;
        logic [PTR_WIDTH-1:0] cand;
        logic                 found;
        gnt   = '0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (PTR_WIDTH + 1)'(i);
            if (sum >= (PTR_WIDTH + 1)'(NUM_REQ)) begin
                sum = sum - (PTR_WIDTH + 1)'(NUM_REQ);
            end
            cand = sum[PTR_WIDTH-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/axi4_lite_write_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_lite_write_arbiter
//
// Shares one AXI4-Lite write master between NUM_REQ local requesters
// (CSR/DMA clients). A pending request is chosen round-robin, its
// address/data/strobe are copied into registers that drive the master, the
// master is kicked with a one-cycle m_wr_en pulse, and the B channel is
// watched for the write response. The response is handed back to the
// granted requester together with a one-cycle done pulse.
//
// The master's active-low resetn is expected to be driven from the
// inverse of this block's reset.
//
// Parameters:
//   NUM_REQ     number of requesters, 2..16
//   ADDR_WIDTH  address width of the write master
//   DATA_WIDTH  data width of the write master; strobe width = DATA_WIDTH/8
//
// Ports:
//   clk        in   1                      clock
//   reset      in   1                      asynchronous, active-high
//   req        in   NUM_REQ                request levels
//   req_addr   in   NUM_REQ*ADDR_WIDTH     requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data   in   NUM_REQ*DATA_WIDTH     requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_strb   in   NUM_REQ*DATA_WIDTH/8   requester i byte strobes
//   gnt        out  NUM_REQ                one-hot, held from grant until DONE
//   done       out  NUM_REQ                one-cycle completion pulse to the winner
//   resp       out  2                      BRESP of the completed write
//   busy       out  1                      high whenever the FSM is not IDLE
//   m_wr_en    out  1                      write-start pulse to the master
//   m_wr_addr  out  ADDR_WIDTH             captured address
//   m_wr_data  out  DATA_WIDTH             captured data
//   m_wr_strb  out  DATA_WIDTH/8           captured strobes
//   m_b_valid  in   1                      B channel valid (monitored)
//   m_b_ready  in   1                      master's B ready (monitored)
//   m_b_resp   in   2                      B channel response (monitored)
// ---------------------------------------------------------------------------
module axi4_lite_write_arbiter
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_strb,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [NUM_REQ-1:0]                done,
    output logic [1:0]                        resp,
    output logic                              busy,
    output logic                              m_wr_en,
    output logic [ADDR_WIDTH-1:0]             m_wr_addr,
    output logic [DATA_WIDTH-1:0]             m_wr_data,
    output logic [DATA_WIDTH/8-1:0]           m_wr_strb,
    input  logic                              m_b_valid,
    input  logic                              m_b_ready,
    input  logic [1:0]                        m_b_resp
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_WIDTH  = $clog2(NUM_REQ);

    state_t                 state;
    state_t                 state_next;

    logic [PTR_WIDTH-1:0]   ptr;
    logic [PTR_WIDTH-1:0]   ptr_after;
    logic [PTR_WIDTH-1:0]   gnt_idx;

    logic [NUM_REQ-1:0]     pick_gnt;
    logic [PTR_WIDTH-1:0]   pick_idx;

    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [STRB_WIDTH-1:0]  sel_strb;

    logic                   any_req;
    logic                   b_fire;

    assign any_req = |req;
    assign b_fire  = m_b_valid && m_b_ready;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_rr_arbiter (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Payload select. The arbiter grant is one-hot, so each requester's
    // slice is gated by its own grant bit and the results are OR-ed
    // together. This keeps the slice indices constant after unrolling and
    // avoids a variable-base part-select.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_strb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = sel_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb = sel_strb | req_strb[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

    // The pointer moves to the position just past the requester that was
    // served, wrapping at NUM_REQ rather than at a power of two.
    always_comb begin
        if (gnt_idx == PTR_WIDTH'(NUM_REQ - 1)) begin
            ptr_after = '0;
        end else begin
            ptr_after = gnt_idx + PTR_WIDTH'(1);
        end
    end

    // FSM state register. Reset is asynchronous so an abort drops back to
    // IDLE in the same cycle it is asserted; every state-decoded output
    // below follows immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-decoded outputs. m_wr_en, busy and done
    // are pure decodes of the state register, so each is exactly as long as
    // the corresponding state: one cycle for ISSUE and DONE. A B handshake is
    // only acted on in WAIT_RESP; one seen anywhere else is ignored.
    always_comb begin
        state_next = state;
        m_wr_en    = 1'b0;
        busy       = 1'b1;
        done       = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                m_wr_en    = 1'b1;
                state_next = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (b_fire) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = gnt;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant, payload, pointer and response registers. The payload is copied
    // at grant time so the requester may change or withdraw its inputs
    // without disturbing the write in flight. gnt is held through DONE so the
    // done pulse can be formed from it, then cleared on the way back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt       <= '0;
            gnt_idx   <= '0;
            ptr       <= '0;
            m_wr_addr <= '0;
            m_wr_data <= '0;
            m_wr_strb <= '0;
            resp      <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt       <= pick_gnt;
                        gnt_idx   <= pick_idx;
                        m_wr_addr <= sel_addr;
                        m_wr_data <= sel_data;
                        m_wr_strb <= sel_strb;
                    end
                end
                WAIT_RESP: begin
                    if (b_fire) begin
                        resp <= m_b_resp;
                    end
                end
                DONE: begin
                    gnt <= '0;
                    ptr <= ptr_after;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_write_arbiter
//
// Scoreboard bench for axi4_lite_write_arbiter (NUM_REQ=4, 32/32).
// Each time a request pattern is driven, the winner predicted by a
// round-robin reference pointer is pushed to a queue with the payload and
// response it should carry. A monitor compares m_wr_* against the queue head
// when m_wr_en pulses and pops/compares when done pulses. A simple B-channel
// responder answers each m_wr_en after a programmable number of cycles.
// ---------------------------------------------------------------------------
module tb_axi4_lite_write_arbiter;
    import axi4_lite_pkg::*;

    localparam int NUM_REQ    = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                              clk;
    logic                              reset;
    logic [NUM_REQ-1:0]                req;
    logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]     req_data;
    logic [NUM_REQ*STRB_WIDTH-1:0]     req_strb;
    logic [NUM_REQ-1:0]                gnt;
    logic [NUM_REQ-1:0]                done;
    logic [1:0]                        resp;
    logic                              busy;
    logic                              m_wr_en;
    logic [ADDR_WIDTH-1:0]             m_wr_addr;
    logic [DATA_WIDTH-1:0]             m_wr_data;
    logic [STRB_WIDTH-1:0]             m_wr_strb;
    logic                              m_b_valid;
    logic                              m_b_ready;
    logic [1:0]                        m_b_resp;

    typedef struct {
        logic [NUM_REQ-1:0]    gnt;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic [1:0]            resp;
    } exp_t;

    exp_t       exp_q[$];
    int         compared;
    int         mismatched;
    int         done_count;
    int         model_ptr;
    int         b_latency;
    logic [1:0] b_resp_cfg;
    bit         slave_en;
    logic       hs_last;
    logic       prev_wr_en;

    axi4_lite_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_strb  (req_strb),
        .gnt       (gnt),
        .done      (done),
        .resp      (resp),
        .busy      (busy),
        .m_wr_en   (m_wr_en),
        .m_wr_addr (m_wr_addr),
        .m_wr_data (m_wr_data),
        .m_wr_strb (m_wr_strb),
        .m_b_valid (m_b_valid),
        .m_b_ready (m_b_ready),
        .m_b_resp  (m_b_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setPayload(input int i, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s);
        req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
        req_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
        req_strb[i*STRB_WIDTH +: STRB_WIDTH] = s;
    endtask

    // Reference round-robin: first set bit at or above model_ptr, wrapping.
    task automatic pushExpect(input logic [NUM_REQ-1:0] mask, input logic [1:0] rsp);
        exp_t e;
        int   win;
        int   j;
        win = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (model_ptr + k) % NUM_REQ;
            if (win < 0 && mask[j]) win = j;
        end
        if (win < 0) win = 0;
        e.gnt  = 4'b0001 << win;
        e.addr = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        e.data = req_data[win*DATA_WIDTH +: DATA_WIDTH];
        e.strb = req_strb[win*STRB_WIDTH +: STRB_WIDTH];
        e.resp = rsp;
        exp_q.push_back(e);
        model_ptr = (win + 1) % NUM_REQ;
    endtask

    task automatic waitWrEn(input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (m_wr_en) seen = 1'b1;
        end
        if (!seen) checkOutput(tag, 64'd0, 64'd1);
    endtask

    task automatic waitDone(input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done != '0) seen = 1'b1;
        end
        if (!seen) checkOutput(tag, 64'd0, 64'd1);
    endtask

    // One isolated transaction: req is raised in an IDLE cycle, must produce
    // m_wr_en on the very next cycle, then is dropped before completion.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] mask,
                                 input logic [1:0] rsp, input int lat);
        @(negedge clk);
        b_resp_cfg = rsp;
        b_latency  = lat;
        req        = mask;
        pushExpect(mask, rsp);
        @(negedge clk);
        checkOutput("issue_latency", 64'(m_wr_en), 64'd1);
        if (!m_wr_en) waitWrEn(20, "wr_en_timeout");
        req = '0;
        waitDone(60, "done_timeout");
    endtask

    // Holds a request pattern for n back-to-back transactions.
    task automatic runHeld(input logic [NUM_REQ-1:0] mask, input int n,
                           input logic [1:0] rsp, input int lat);
        @(negedge clk);
        b_resp_cfg = rsp;
        b_latency  = lat;
        req        = mask;
        for (int k = 0; k < n; k++) pushExpect(mask, rsp);
        for (int k = 0; k < n; k++) waitDone(60, "held_done_timeout");
        req = '0;
    endtask

    // B-channel responder: answers each m_wr_en after b_latency cycles.
    initial begin
        m_b_valid = 1'b0;
        m_b_ready = 1'b0;
        m_b_resp  = 2'b00;
        forever begin
            @(negedge clk);
            if (m_wr_en && slave_en && !reset) begin
                repeat (b_latency) @(negedge clk);
                m_b_valid = 1'b1;
                m_b_ready = 1'b1;
                m_b_resp  = b_resp_cfg;
                @(negedge clk);
                m_b_valid = 1'b0;
                m_b_ready = 1'b0;
                m_b_resp  = 2'b00;
            end
        end
    end

    // Remembers whether the B handshake was presented at the latest edge.
    initial begin
        hs_last = 1'b0;
        forever begin
            @(posedge clk);
            hs_last = m_b_valid && m_b_ready;
        end
    end

    // Monitor: checks issued payload against the queue head, pops on done.
    initial begin
        exp_t e;
        prev_wr_en = 1'b0;
        done_count = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (m_wr_en) begin
                    checkOutput("wr_en_single_cycle", 64'(prev_wr_en), 64'd0);
                    checkOutput("busy_in_issue", 64'(busy), 64'd1);
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_write", 64'(m_wr_en), 64'd0);
                    end else begin
                        e = exp_q[0];
                        checkOutput("gnt", 64'(gnt), 64'(e.gnt));
                        checkOutput("m_wr_addr", 64'(m_wr_addr), 64'(e.addr));
                        checkOutput("m_wr_data", 64'(m_wr_data), 64'(e.data));
                        checkOutput("m_wr_strb", 64'(m_wr_strb), 64'(e.strb));
                    end
                end
                if (done != '0) begin
                    done_count++;
                    checkOutput("done_after_b", 64'(hs_last), 64'd1);
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_done", 64'(done), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("done", 64'(done), 64'(e.gnt));
                        checkOutput("resp", 64'(resp), 64'(e.resp));
                        checkOutput("gnt_held", 64'(gnt), 64'(e.gnt));
                        checkOutput("data_at_done", 64'(m_wr_data), 64'(e.data));
                    end
                end
            end
            prev_wr_en = m_wr_en;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dc0;
        compared   = 0;
        mismatched = 0;
        model_ptr  = 0;
        b_latency  = 2;
        b_resp_cfg = RESP_OKAY;
        slave_en   = 1'b1;
        reset      = 1'b1;
        req        = '0;
        req_addr   = '0;
        req_data   = '0;
        req_strb   = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        checkOutput("rst_gnt", 64'(gnt), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_resp", 64'(resp), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_wr_en", 64'(m_wr_en), 64'd0);
        checkOutput("rst_addr", 64'(m_wr_addr), 64'd0);
        checkOutput("rst_data", 64'(m_wr_data), 64'd0);
        checkOutput("rst_strb", 64'(m_wr_strb), 64'd0);
        reset = 1'b0;

        // All four held: order 0,1,2,3,0,1,2,3.
        for (int i = 0; i < NUM_REQ; i++) begin
            setPayload(i, 32'h1000 + 32'(i * 16), 32'hA500_0000 + 32'(i), 4'(4'hF >> i));
        end
        runHeld(4'b1111, 8, RESP_OKAY, 1);

        // Single request, B two cycles after issue.
        setPayload(0, 32'h10, 32'hDEAD_BEEF, 4'hF);
        applyStimulus(4'b0001, RESP_OKAY, 2);

        // Grant to 2 leaves ptr=3; then 0 wins by wrap, then 1.
        applyStimulus(4'b0100, RESP_OKAY, 1);
        runHeld(4'b0011, 2, RESP_OKAY, 2);

        // SLVERR passes through; the following write is normal.
        applyStimulus(4'b1000, RESP_SLVERR, 2);
        applyStimulus(4'b0010, RESP_OKAY, 1);

        // Drop req and change the payload right after grant.
        setPayload(2, 32'h200, 32'h600D_F00D, 4'hF);
        @(negedge clk);
        b_resp_cfg = RESP_OKAY;
        b_latency  = 3;
        req        = 4'b0100;
        pushExpect(4'b0100, RESP_OKAY);
        waitWrEn(20, "t6_wr_en_timeout");
        dc0 = done_count;
        req = '0;
        setPayload(2, 32'h999, 32'hBAD0_BAD0, 4'h1);
        @(negedge clk);
        checkOutput("t6_data_held", 64'(m_wr_data), 64'h600D_F00D);
        checkOutput("t6_addr_held", 64'(m_wr_addr), 64'h200);
        waitDone(60, "t6_done_timeout");
        repeat (6) @(negedge clk);
        checkOutput("t6_done_once", 64'(done_count - dc0), 64'd1);

        // Reset while waiting for the response.
        setPayload(1, 32'h300, 32'h1234_5678, 4'h3);
        slave_en = 1'b0;
        @(negedge clk);
        req = 4'b0010;
        pushExpect(4'b0010, RESP_OKAY);
        waitWrEn(20, "t5_wr_en_timeout");
        req = '0;
        repeat (2) @(negedge clk);
        checkOutput("t5_busy_wait", 64'(busy), 64'd1);
        checkOutput("t5_gnt_wait", 64'(gnt), 64'b0010);
        dc0 = done_count;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_gnt_rst", 64'(gnt), 64'd0);
        checkOutput("t5_busy_rst", 64'(busy), 64'd0);
        checkOutput("t5_wr_en_rst", 64'(m_wr_en), 64'd0);
        checkOutput("t5_done_rst", 64'(done), 64'd0);
        checkOutput("t5_addr_rst", 64'(m_wr_addr), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model_ptr = 0;
        slave_en  = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("t5_no_done", 64'(done_count - dc0), 64'd0);

        // ptr restarts at 0: 0 wins over 3 with req=1001.
        setPayload(0, 32'h400, 32'h0BAD_CAFE, 4'hC);
        setPayload(3, 32'h430, 32'h0000_0003, 4'h8);
        applyStimulus(4'b1001, RESP_DECERR, 1);

        // Random patterns, latencies and responses.
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                setPayload(i, $urandom, $urandom, 4'($urandom_range(0, 15)));
            end
            applyStimulus(4'($urandom_range(1, 15)), 2'($urandom_range(0, 3)),
                          $urandom_range(1, 4));
        end

        repeat (5) @(negedge clk);
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
